// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and the frame receiver state encoding.
package ps2_pkg;

  // Scan-code prefixes
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Arrow keys that drive the box-resize logic
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  // Frame FSM state encoding
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronizer, clock glitch filter, 11-bit frame FSM
// and inactivity timeout. Emits one byte_valid_o or one frame_err_o per frame.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [1:0]            clk_sync_q;
  logic [1:0]            data_sync_q;
  logic [FILTER_LEN-1:0] filt_sh_q;
  logic                  filt_q;
  logic                  fall;
  logic                  data_s;

  ps2_state_e            state_q, state_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic [7:0]            byte_q, byte_d;
  logic                  par_q, par_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  byte_valid_q, byte_valid_d;
  logic                  frame_err_q, frame_err_d;

  // Synchronize both lines and debounce the keyboard clock
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_sh_q   <= '1;
      filt_q      <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_sh_q   <= {filt_sh_q[FILTER_LEN-2:0], clk_sync_q[1]};
      if (&filt_sh_q) begin
        filt_q <= 1'b1;
      end else if (~|filt_sh_q) begin
        filt_q <= 1'b0;
      end
    end
  end

  // Falling edge of the filtered clock: high for the single cycle before filt_q drops
  assign fall   = filt_q & ~|filt_sh_q;
  assign data_s = data_sync_q[1];

  // Frame state and strobe registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      bitcnt_q     <= '0;
      byte_q       <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      byte_q       <= byte_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Frame FSM next state, advanced only on filtered falling edges or timeout
  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    byte_d       = byte_q;
    par_d        = par_q;
    tmo_d        = tmo_q + TmoW'(1);
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (fall || state_q == StIdle) begin
      tmo_d = '0;
    end

    if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!data_s) begin
            state_d  = StData;
            bitcnt_d = '0;
          end
        end
        StData: begin
          byte_d[bitcnt_q] = data_s;
          if (bitcnt_q == 3'd7) begin
            state_d = StParity;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
        StParity: begin
          par_d   = data_s;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          // Odd parity over data+parity and a high stop bit make a good frame
          if (data_s && (^{byte_q, par_q})) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && tmo_q == TmoLast) begin
      state_d     = StIdle;
      frame_err_d = 1'b1;
      tmo_d       = '0;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: strips E0/F0 prefixes and strobes flagkey once per make code.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       flagkey,
  output logic       extended,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [7:0] scancode_q, scancode_d;
  logic       extended_q, extended_d;
  logic       flagkey_q, flagkey_d;
  logic       frame_err_q, frame_err_d;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk_i        (clk),
    .reset_i      (reset),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err)
  );

  // Prefix flags and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      scancode_q  <= '0;
      extended_q  <= 1'b0;
      flagkey_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      scancode_q  <= scancode_d;
      extended_q  <= extended_d;
      flagkey_q   <= flagkey_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Prefix decode; frame_err is re-registered so both strobes share the same latency
  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    scancode_d  = scancode_q;
    extended_d  = extended_q;
    flagkey_d   = 1'b0;
    frame_err_d = rx_err;

    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == PS2_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_PREFIX_BRK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        // Release code: swallow it so a key-up never looks like a press
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else begin
        scancode_d = rx_byte;
        extended_d = ext_q;
        flagkey_d  = 1'b1;
        ext_d      = 1'b0;
      end
    end
  end

  assign scancode  = scancode_q;
  assign flagkey   = flagkey_q;
  assign extended  = extended_q;
  assign frame_err = frame_err_q;

endmodule
